sd_cic_decimator: RTL and testbench
===================================

// Module: sd_cic_decimator
// PURPOSE
//  Parametrised N-stage CIC (Hogenauer) decimator for sigma-delta modulator streams.
//  Successor to the fixed 5-tap sd_digital_filter: configurable order, decimation ratio and widths.
//  Adds valid-qualified input, decimation phase sync, and a registered output strobe.
//  Sits between the modulator bitstream/oversampled bus and the compensation FIR / host readout.
// PARAMETERS
//  IN_W   16  signed input sample width (1 = raw bitstream mapped by caller to +/-1)
//  ORDER  3   number of integrator and comb stages N (1..6)
//  DEC_R  64  decimation ratio R (2..4096), differential delay M fixed at 1
//  OUT_W  24  signed output width; must satisfy OUT_W <= ACC_W
//  ACC_W  derived localparam = IN_W + ORDER*clog2(DEC_R); SHIFT = ACC_W - OUT_W
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  reset      in   1      asynchronous, active-high; clears all state
//  in_valid   in   1      qualifies in_data; one sample accepted per cycle when high
//  in_data    in   IN_W   signed two's-complement oversampled sample
//  sync       in   1      restart decimation phase (see BEHAVIOUR)
//  out_valid  out  1      one-cycle pulse per decimated sample
//  out_data   out  OUT_W  signed decimated result, held between pulses
//  phase      out  clog2(DEC_R)  current decimation counter value (debug/alignment)
// BEHAVIOUR
//  Reset: integrators, comb delays, comb pipeline, counter, out_data, phase = 0; out_valid = 0.
//  Reset asserted mid-operation discards everything in flight; no out_valid until R new samples.
//  Integrators: on in_valid, integ[0] <= integ[0] + sext(in_data); integ[k] <= integ[k] + integ[k-1]
//   (previous-cycle value, pipelined). No update when in_valid low. All ACC_W wide, modulo 2^ACC_W;
//   wraparound is intended and exact because comb differences cancel it.
//  Counter: increments on each in_valid; at DEC_R-1 with in_valid -> wraps to 0 and raises dec strobe.
//  sync: if high with in_valid, that sample is treated as phase 0 (counter <= 1, or dec if DEC_R==1 n/a);
//   if high without in_valid, counter <= 0. Integrators are never cleared by sync.
//  Combs: fully pipelined, one stage per cycle, valid bit travels with data.
//   Edge t accepts R-th sample; edge t+1: comb[0] = integ[N-1] - dly[0], dly[0] <= integ[N-1];
//   edge t+1+k: comb[k] = comb[k-1] - dly[k]; dly[k] <= comb[k-1].
//  Output: out_data <= comb[N-1] >>> SHIFT (arithmetic, truncate toward -inf) at edge t+N+1,
//   out_valid high for exactly that cycle. Latency N+1 cycles from the R-th accepting edge.
//  DC gain = R^N; full-scale input never overflows ACC_W; truncation only drops LSBs.
//  Continuous in_valid is supported; pipeline never stalls, no backpressure, no overrun condition.
//  phase reflects counter register value (0..DEC_R-1).
// STRUCTURE
//  Shared package sd_filter_pkg: clog2 function, cic_acc_w(IN_W,ORDER,DEC_R) function,
//   ORDER/DEC_R legal-range constants; elaboration-time check OUT_W <= ACC_W.
//  Sub-module sd_cic_comb_stage (ACC_W): valid-in, data-in -> registered difference + delay reg;
//   instantiated ORDER times via generate. Integrator chain and counter stay in top.
// TESTING  (IN_W=16, ORDER=3, DEC_R=4, OUT_W=16 -> ACC_W=22, SHIFT=6)
//  DC: in_valid=1, in_data=1000 continuous -> after 3 outputs, every out_data=1000, pulse every 4 cycles.
//  Impulse: in_data=64 once then 0, any phase -> decimated outputs sum to 16, then all 0.
//  Full scale: continuous -32768 -> settles to -32768; continuous +32767 -> 32767; no wrap errors.
//  Gapped valid: in_valid 1-in-3, DC 500 -> out_data 500, out_valid only after every 4th accepted sample.
//  sync: assert sync with in_valid at counter=2 -> next out_valid exactly N+1+3 cycles after sync sample edge.
//  Reset mid-stream: assert reset during comb pipeline -> out_valid/out_data 0 immediately; first pulse only
//   after 4 new accepted samples + 4 cycles.

Source files
------------

// File: rtl/sd_filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : sd_filter_pkg
//  Brief   : Shared constants and elaboration helpers for the sigma-delta
//            decimation filters (legal parameter ranges, width helpers).
//  Revision: 1.0  initial release
// ============================================================================
package sd_filter_pkg;

    // Legal range of the CIC order (number of integrator/comb pairs).
    localparam int ORDER_MIN = 1;
    localparam int ORDER_MAX = 6;

    // Legal range of the decimation ratio R.
    localparam int DEC_R_MIN = 2;
    localparam int DEC_R_MAX = 4096;

    // Ceiling log2, usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Accumulator width that holds the full CIC gain R^N without overflow.
    function automatic int cic_acc_w(input int in_w, input int order, input int dec_r);
        return in_w + order * clog2(dec_r);
    endfunction

    // Number of LSBs dropped between the accumulator and the output word.
    function automatic int cic_shift(input int in_w, input int order, input int dec_r,
                                     input int out_w);
        return cic_acc_w(in_w, order, dec_r) - out_w;
    endfunction

endpackage : sd_filter_pkg
`default_nettype wire

// File: rtl/sd_cic_comb_stage.sv
`default_nettype none
// ============================================================================
//  Module  : sd_cic_comb_stage
//  Brief   : One CIC comb section with differential delay 1. On each valid
//            input it registers (data - previous data) and remembers the
//            input; the valid bit travels alongside with one cycle latency.
//  Revision: 1.0  initial release
// ============================================================================
module sd_cic_comb_stage #(
    parameter int ACC_W = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [ACC_W-1:0] data_i,
    output logic             valid_o,
    output logic [ACC_W-1:0] data_o
);

    logic             valid_q;
    logic [ACC_W-1:0] data_q;
    logic [ACC_W-1:0] dly_q;

    // Difference against the previous decimated value; modulo arithmetic is
    // intentional, wraparound from the integrators cancels here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            dly_q   <= '0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q <= data_i - dly_q;
                dly_q  <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule : sd_cic_comb_stage
`default_nettype wire

// File: rtl/sd_cic_decimator.sv
`default_nettype none
// ============================================================================
//  Module  : sd_cic_decimator
//  Brief   : Parametrised N-stage CIC (Hogenauer) decimator for sigma-delta
//            streams. Valid-qualified input, decimation phase sync, pipelined
//            integrators and combs, registered output strobe.
//  Revision: 1.0  initial release
// ============================================================================
module sd_cic_decimator
    import sd_filter_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int ORDER = 3,
    parameter int DEC_R = 64,
    parameter int OUT_W = 24
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    input  logic signed [IN_W-1:0]          in_data,
    input  logic                            sync,
    output logic                            out_valid,
    output logic signed [OUT_W-1:0]         out_data,
    output logic [sd_filter_pkg::clog2(DEC_R)-1:0] phase
);

    localparam int ACC_W = cic_acc_w(IN_W, ORDER, DEC_R);
    localparam int SHIFT = cic_shift(IN_W, ORDER, DEC_R, OUT_W);
    localparam int PH_W  = clog2(DEC_R);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DEC_R - 1);

    // ------------------------------------------------------------------------
    // Parameter sanity checks, resolved at elaboration.
    // ------------------------------------------------------------------------
    generate
        if (OUT_W > ACC_W) begin : g_chk_out_w
            $error("sd_cic_decimator: OUT_W (%0d) exceeds ACC_W (%0d)", OUT_W, ACC_W);
        end
        if ((ORDER < ORDER_MIN) || (ORDER > ORDER_MAX)) begin : g_chk_order
            $error("sd_cic_decimator: ORDER (%0d) out of range", ORDER);
        end
        if ((DEC_R < DEC_R_MIN) || (DEC_R > DEC_R_MAX)) begin : g_chk_dec_r
            $error("sd_cic_decimator: DEC_R (%0d) out of range", DEC_R);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Integrator chain. Each stage adds the previous-cycle value of the stage
    // before it, so the adder path is one stage deep regardless of ORDER.
    // ------------------------------------------------------------------------
    logic [ACC_W-1:0] in_ext;
    logic [ACC_W-1:0] integ_q [ORDER];
    logic [ACC_W-1:0] integ_d [ORDER];

    assign in_ext = {{(ACC_W - IN_W){in_data[IN_W-1]}}, in_data};

    // Next-state of every integrator for an accepted sample.
    always_comb begin
        integ_d[0] = integ_q[0] + in_ext;
        for (int k = 1; k < ORDER; k++) begin
            integ_d[k] = integ_q[k] + integ_q[k-1];
        end
    end

    // Integrators advance only on accepted samples and are never cleared by sync.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= '0;
            end
        end else if (in_valid) begin
            integ_q <= integ_d;
        end
    end

    // ------------------------------------------------------------------------
    // Decimation counter. sync with a sample makes that sample phase 0; sync
    // alone parks the counter at 0. The strobe marks the R-th accepted edge.
    // ------------------------------------------------------------------------
    logic [PH_W-1:0] cnt_q;
    logic [PH_W-1:0] cnt_d;
    logic            dec_q;
    logic            dec_d;

    // Counter next-state and decimation strobe decode.
    always_comb begin
        cnt_d = cnt_q;
        dec_d = 1'b0;
        if (in_valid) begin
            if (sync) begin
                cnt_d = PH_W'(1);
            end else if (cnt_q == PH_LAST) begin
                cnt_d = '0;
                dec_d = 1'b1;
            end else begin
                cnt_d = cnt_q + PH_W'(1);
            end
        end else if (sync) begin
            cnt_d = '0;
        end
    end

    // Counter and strobe registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            dec_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dec_q <= dec_d;
        end
    end

    assign phase = cnt_q;

    // ------------------------------------------------------------------------
    // Comb pipeline: one stage per cycle, valid travels with the data. The
    // strobe is one cycle behind the accepting edge, which lines it up with
    // the integrator value that includes the R-th sample.
    // ------------------------------------------------------------------------
    logic             comb_valid [ORDER+1];
    logic [ACC_W-1:0] comb_data  [ORDER+1];

    assign comb_valid[0] = dec_q;
    assign comb_data[0]  = integ_q[ORDER-1];

    generate
        for (genvar g = 0; g < ORDER; g++) begin : g_comb
            sd_cic_comb_stage #(
                .ACC_W (ACC_W)
            ) u_comb (
                .clk     (clk),
                .reset   (reset),
                .valid_i (comb_valid[g]),
                .data_i  (comb_data[g]),
                .valid_o (comb_valid[g+1]),
                .data_o  (comb_data[g+1])
            );
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Output register. Taking the top OUT_W bits is an arithmetic shift right
    // by SHIFT followed by truncation, i.e. rounding toward -inf.
    // ------------------------------------------------------------------------
    logic                    out_valid_q;
    logic signed [OUT_W-1:0] out_data_q;

    generate
        if (SHIFT > 0) begin : g_drop_lsbs
            logic unused_lsbs;
            assign unused_lsbs = ^comb_data[ORDER][SHIFT-1:0];
        end
    endgenerate

    // Capture the scaled comb result and raise a one-cycle strobe with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= comb_valid[ORDER];
            if (comb_valid[ORDER]) begin
                out_data_q <= comb_data[ORDER][ACC_W-1:SHIFT];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule : sd_cic_decimator
`default_nettype wire

// File: tb/tb_sd_cic_decimator.sv
`default_nettype none
// ============================================================================
//  Module  : tb_sd_cic_decimator
//  Brief   : Self-checking bench for sd_cic_decimator (N=3, R=4, 16->16 bit).
//            Expected outputs come from a direct convolution with the CIC
//            impulse response, queued with their due cycle.
//  Revision: 1.0  initial release
// ============================================================================
module tb_sd_cic_decimator;

    localparam int IN_W  = 16;
    localparam int ORDER = 3;
    localparam int DEC_R = 4;
    localparam int OUT_W = 16;
    localparam int SHIFT = 6;
    localparam int NTAPS = ORDER * (DEC_R - 1) + 1;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic signed [IN_W-1:0]  in_data;
    logic                    sync;
    logic                    out_valid;
    logic signed [OUT_W-1:0] out_data;
    logic [1:0]              phase;

    sd_cic_decimator #(
        .IN_W  (IN_W),
        .ORDER (ORDER),
        .DEC_R (DEC_R),
        .OUT_W (OUT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .sync      (sync),
        .out_valid (out_valid),
        .out_data  (out_data),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                      cyc;
        bit                      chk;
        logic signed [OUT_W-1:0] data;
    } exp_t;

    exp_t   sb[$];
    longint xs[$];
    longint h [NTAPS];
    int     pulses[$];
    longint obs_sum;
    int     cyc = 0;
    int     n_vec = 0;
    int     n_err = 0;
    int     m_phase;
    int     skip;

    always @(posedge clk) cyc <= cyc + 1;

    // CIC impulse response: ORDER-fold convolution of a length-R boxcar.
    task automatic build_taps();
        longint t [NTAPS];
        int len;
        for (int i = 0; i < NTAPS; i++) h[i] = 0;
        h[0] = 1;
        len  = 1;
        for (int s = 0; s < ORDER; s++) begin
            for (int i = 0; i < NTAPS; i++) t[i] = 0;
            for (int i = 0; i < len; i++)
                for (int k = 0; k < DEC_R; k++) t[i+k] += h[i];
            len += DEC_R - 1;
            for (int i = 0; i < NTAPS; i++) h[i] = t[i];
        end
    endtask

    // Decimated output for the newest accepted sample; the pipelined
    // integrators add ORDER-1 samples of delay.
    function automatic longint model_out();
        longint acc;
        int     n;
        acc = 0;
        n   = xs.size() - 1;
        for (int j = 0; j < NTAPS; j++) begin
            int idx;
            idx = n - (ORDER - 1) - j;
            if (idx >= 0) acc += h[j] * xs[idx];
        end
        return acc >>> SHIFT;
    endfunction

    // Scoreboard monitor: every pulse must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            pulses.push_back(cyc);
            obs_sum += longint'(out_data);
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: out_valid=1 at cycle %0d, required none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc !== e.cyc) begin
                    n_err++;
                    $display("FAIL pulse_cycle: got cycle %0d, required %0d", cyc, e.cyc);
                end
                if (e.chk) begin
                    n_vec++;
                    if (out_data !== e.data) begin
                        n_err++;
                        $display("FAIL out_data: got %0d, required %0d (cycle %0d)",
                                 out_data, e.data, cyc);
                    end
                end
            end
        end
    end

    // One input cycle; also checks the phase left by the previous cycle.
    task automatic drive(input bit v, input int d, input bit s);
        @(negedge clk);
        n_vec++;
        if (phase !== 2'(m_phase)) begin
            n_err++;
            $display("FAIL phase: got %0d, required %0d (cycle %0d)", phase, m_phase, cyc);
        end
        in_valid = v;
        in_data  = 16'(d);
        sync     = s;
        if (v) begin
            xs.push_back(longint'(in_data));
            if (s) begin
                m_phase = 1;
                skip    = ORDER;
            end else if (m_phase == DEC_R - 1) begin
                exp_t e;
                m_phase = 0;
                e.cyc   = cyc + 1 + ORDER + 1;
                e.chk   = (skip == 0);
                e.data  = 16'(model_out());
                if (skip > 0) skip--;
                sb.push_back(e);
            end else begin
                m_phase++;
            end
        end else if (s) begin
            m_phase = 0;
            skip    = ORDER;
        end
    endtask

    task automatic do_reset(input bit chk);
        @(negedge clk);
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        sync     = 1'b0;
        in_data  = '0;
        sb.delete();
        xs.delete();
        m_phase  = 0;
        skip     = 0;
        #1;
        if (chk) begin
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL mid_reset_valid: got %b, required 0", out_valid);
            end
            n_vec++;
            if (out_data !== 16'sd0) begin
                n_err++;
                $display("FAIL mid_reset_data: got %0d, required 0", out_data);
            end
            n_vec++;
            if (phase !== 2'd0) begin
                n_err++;
                $display("FAIL mid_reset_phase: got %0d, required 0", phase);
            end
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        pulses.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got %b, required 0", out_valid);
        end
        n_vec++;
        if (out_data !== 16'sd0) begin
            n_err++;
            $display("FAIL reset_data: got %0d, required 0", out_data);
        end
        n_vec++;
        if (phase !== 2'd0) begin
            n_err++;
            $display("FAIL reset_phase: got %0d, required 0", phase);
        end
        reset = 1'b0;
    endtask

    task automatic test_dc();
        for (int i = 0; i < 40; i++) drive(1'b1, 1000, 1'b0);
        n_vec++;
        if (out_data !== 16'sd1000) begin
            n_err++;
            $display("FAIL dc_settled: got %0d, required 1000", out_data);
        end
    endtask

    task automatic test_full_scale();
        for (int i = 0; i < 40; i++) drive(1'b1, -32768, 1'b0);
        n_vec++;
        if (out_data !== -16'sd32768) begin
            n_err++;
            $display("FAIL full_scale_neg: got %0d, required -32768", out_data);
        end
        for (int i = 0; i < 40; i++) drive(1'b1, 32767, 1'b0);
        n_vec++;
        if (out_data !== 16'sd32767) begin
            n_err++;
            $display("FAIL full_scale_pos: got %0d, required 32767", out_data);
        end
    endtask

    task automatic test_impulse();
        do_reset(1'b0);
        obs_sum = 0;
        drive(1'b1, 0, 1'b0);
        drive(1'b1, 0, 1'b0);
        drive(1'b1, 64, 1'b0);
        for (int i = 0; i < 24; i++) drive(1'b1, 0, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b0, 0, 1'b0);
        n_vec++;
        if (obs_sum !== 64'sd16) begin
            n_err++;
            $display("FAIL impulse_sum: got %0d, required 16", obs_sum);
        end
    endtask

    task automatic test_gapped();
        for (int i = 0; i < 60; i++) drive((i % 3) == 0, 500, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b0, 0, 1'b0);
        n_vec++;
        if (out_data !== 16'sd500) begin
            n_err++;
            $display("FAIL gapped_dc: got %0d, required 500", out_data);
        end
    endtask

    task automatic test_sync();
        int s_edge;
        int first;
        for (int i = 0; i < 8; i++) begin
            if (m_phase != 2) drive(1'b1, 200, 1'b0);
        end
        pulses.delete();
        drive(1'b1, 200, 1'b1);
        s_edge = cyc + 1;
        for (int i = 0; i < 12; i++) drive(1'b1, 200, 1'b0);
        first = -1;
        foreach (pulses[i]) begin
            if (first < 0 && pulses[i] > s_edge + ORDER) first = pulses[i];
        end
        n_vec++;
        if (first !== s_edge + ORDER + 1 + 3) begin
            n_err++;
            $display("FAIL sync_latency: first pulse at cycle %0d, required %0d",
                     first, s_edge + ORDER + 1 + 3);
        end
        // Sync without a sample parks the phase at 0.
        drive(1'b0, 0, 1'b1);
        for (int i = 0; i < 24; i++) drive(1'b1, -300, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b0, 0, 1'b0);
        n_vec++;
        if (out_data !== -16'sd300) begin
            n_err++;
            $display("FAIL sync_dc: got %0d, required -300", out_data);
        end
    endtask

    task automatic test_reset_mid();
        int a1;
        for (int i = 0; i < 20; i++) drive(1'b1, 1000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (m_phase != 0) drive(1'b1, 1000, 1'b0);
        end
        drive(1'b1, 1000, 1'b0);
        do_reset(1'b1);
        drive(1'b1, 1000, 1'b0);
        a1 = cyc + 1;
        for (int i = 0; i < 11; i++) drive(1'b1, 1000, 1'b0);
        n_vec++;
        if (pulses.size() == 0 || pulses[0] !== a1 + 3 + ORDER + 1) begin
            n_err++;
            $display("FAIL reset_restart: first pulse at cycle %0d, required %0d",
                     (pulses.size() == 0) ? -1 : pulses[0], a1 + 3 + ORDER + 1);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 12; i++) drive(1'b0, 0, 1'b0);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL missing_pulses: %0d outputs outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        sync     = 1'b0;
        m_phase  = 0;
        skip     = 0;
        obs_sum  = 0;
        build_taps();
        test_reset();
        test_dc();
        test_full_scale();
        test_impulse();
        test_gapped();
        test_sync();
        test_reset_mid();
        test_drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule : tb_sd_cic_decimator
`default_nettype wire
